// File: rtl/rec_fifo.sv
// rtl/rec_fifo.sv - FIFO of packed {a,b,t} records with same-cycle push/pop on full
// Also captures the most recently accepted record in last_rec.
module rec_fifo #(
  parameter  int A_W   = 1,
  parameter  int B_W   = 8,
  parameter  int T_W   = 8,
  parameter  int DEPTH = 4,
  localparam int R_W   = A_W + B_W + T_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [B_W-1:0] in_b,
  input  logic [T_W-1:0] in_t,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [R_W-1:0] out_rec,
  output logic [A_W-1:0] out_a,
  output logic [B_W-1:0] out_b,
  output logic [T_W-1:0] out_t,
  output logic [CW-1:0]  count,
  output logic [R_W-1:0] last_rec
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [T_W-1:0] t;
  } rec_t;

  rec_t          r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  rec_t          r_last;

  rec_t w_in_rec;
  rec_t w_head;
  logic w_push;
  logic w_pop;

  assign w_in_rec = '{a: in_a, b: in_b, t: in_t};
  assign w_head   = r_mem[r_rptr];

  // Reset overrides the handshake so the producer sees ready and the consumer sees nothing.
  assign out_valid = rst_n && (r_count != '0);
  assign in_ready  = !rst_n || (r_count < FULL_C) || out_ready;

  assign w_push = rst_n && in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  assign out_rec  = w_head;
  assign out_a    = out_rec[R_W-1 -: A_W];
  assign out_b    = out_rec[T_W +: B_W];
  assign out_t    = out_rec[T_W-1:0];
  assign count    = r_count;
  assign last_rec = r_last;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_in_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        r_last <= w_in_rec;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
